// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline-stage control bundle layout, reset encodings and helpers
package pipe_pkg;

  // IF/ID control bundle
  localparam int IFID_BIT_PRED_TAKEN  = 0;
  localparam int IFID_BIT_FETCH_FAULT = 1;
  localparam int IFID_CTRL_W          = 2;

  // ID/EX control bundle
  localparam int IDEX_BIT_REG_WRITE  = 0;
  localparam int IDEX_BIT_MEM_READ   = 1;
  localparam int IDEX_BIT_MEM_WRITE  = 2;
  localparam int IDEX_BIT_MEM_TO_REG = 3;
  localparam int IDEX_BIT_ALU_SRC    = 4;
  localparam int IDEX_BIT_BR_Z       = 5;
  localparam int IDEX_BIT_BR_NZ      = 6;
  localparam int IDEX_BIT_JUMP       = 7;
  localparam int IDEX_ALU_OP_LSB     = 8;
  localparam int IDEX_ALU_OP_W       = 4;
  localparam int IDEX_CTRL_W         = 16;

  // EX/MEM/WB control bundle
  localparam int EXWB_BIT_REG_WRITE  = 0;
  localparam int EXWB_BIT_MEM_READ   = 1;
  localparam int EXWB_BIT_MEM_WRITE  = 2;
  localparam int EXWB_BIT_MEM_TO_REG = 3;
  localparam int EXWB_CTRL_W         = 4;

  // All-zero is the side-effect-free encoding for every stage bundle
  localparam logic [IFID_CTRL_W-1:0] IFID_CTRL_RST = '0;
  localparam logic [IDEX_CTRL_W-1:0] IDEX_CTRL_RST = '0;
  localparam logic [EXWB_CTRL_W-1:0] EXWB_CTRL_RST = '0;

  typedef struct packed {
    logic [3:0] spare;
    logic [3:0] alu_op;
    logic       jump;
    logic       br_nz;
    logic       br_z;
    logic       alu_src;
    logic       mem_to_reg;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
  } idex_ctrl_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // The skid entry is only ever valid behind a valid main entry
  function automatic occ_e occupancy(input logic main_valid, input logic skid_valid);
    if (main_valid && skid_valid) return OCC_TWO;
    if (main_valid || skid_valid) return OCC_ONE;
    return OCC_EMPTY;
  endfunction

endpackage

// File: rtl/pipe_reg_slot.sv
// rtl/pipe_reg_slot.sv - one valid + data + ctrl register with load and clear enables
module pipe_reg_slot #(
  parameter int                 DATA_W   = 96,
  parameter int                 CTRL_W   = 16,
  parameter logic [CTRL_W-1:0]  CTRL_RST = {CTRL_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CTRL_W-1:0] load_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // Clear wins over load; data is left alone on clear so only ctrl must be scrubbed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= CTRL_RST;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= CTRL_RST;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      ctrl  <= load_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - parametrised pipeline-stage register with handshake, flush and optional skid entry
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int                 DATA_W   = 96,
  parameter int                 CTRL_W   = 16,
  parameter logic [CTRL_W-1:0]  CTRL_RST = {CTRL_W{1'b0}},
  parameter int                 SKID     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        level
);

  logic              main_load;
  logic              main_clear;
  logic [DATA_W-1:0] main_src_data;
  logic [CTRL_W-1:0] main_src_ctrl;
  logic              main_valid;

  pipe_reg_slot #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .CTRL_RST (CTRL_RST)
  ) u_main (
    .clk       (clk),
    .rst       (rst),
    .clear     (main_clear),
    .load      (main_load),
    .load_data (main_src_data),
    .load_ctrl (main_src_ctrl),
    .valid     (main_valid),
    .data      (out_data),
    .ctrl      (out_ctrl)
  );

  assign out_valid = main_valid;

  generate
    if (SKID != 0) begin : g_skid
      logic              skid_load;
      logic              skid_clear;
      logic              skid_valid;
      logic [DATA_W-1:0] skid_data;
      logic [CTRL_W-1:0] skid_ctrl;
      logic              accept;
      logic              main_free;

      pipe_reg_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CTRL_RST (CTRL_RST)
      ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .clear     (skid_clear),
        .load      (skid_load),
        .load_data (in_data),
        .load_ctrl (in_ctrl),
        .valid     (skid_valid),
        .data      (skid_data),
        .ctrl      (skid_ctrl)
      );

      // in_ready comes straight from a flop, so out_ready never reaches upstream
      assign in_ready  = !skid_valid;
      assign accept    = in_valid && in_ready;
      assign main_free = !main_valid || out_ready;

      always_comb begin
        main_load     = 1'b0;
        main_clear    = 1'b0;
        skid_load     = 1'b0;
        skid_clear    = 1'b0;
        main_src_data = skid_valid ? skid_data : in_data;
        main_src_ctrl = skid_valid ? skid_ctrl : in_ctrl;
        if (flush) begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end else if (main_free) begin
          if (skid_valid) begin
            main_load  = 1'b1;
            skid_clear = 1'b1;
          end else if (accept) begin
            main_load  = 1'b1;
          end else begin
            main_clear = 1'b1;
          end
        end else if (accept) begin
          skid_load = 1'b1;
        end
      end

      assign level = occupancy(main_valid, skid_valid);
    end else begin : g_single
      assign in_ready      = !main_valid || out_ready;
      assign main_src_data = in_data;
      assign main_src_ctrl = in_ctrl;
      // An open slot with no incoming payload takes a bubble
      assign main_load     = !flush && in_valid && in_ready;
      assign main_clear    = flush || (in_ready && !in_valid);
      assign level         = occupancy(main_valid, 1'b0);
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - self-checking bench for pipe_stage_buf in single and skid configurations
module tb_pipe_stage_buf;

  localparam int          DW       = 96;
  localparam int          CW       = 16;
  localparam logic [15:0] A_CTRL_RST = 16'h0000;
  localparam logic [15:0] B_CTRL_RST = 16'h8001;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [CW-1:0] a_in_ctrl, a_out_ctrl;
  logic [1:0]    a_level;

  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [CW-1:0] b_in_ctrl, b_out_ctrl;
  logic [1:0]    b_level;

  ent_t qa[$];
  ent_t qb[$];
  bit   a_acc, b_acc;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST(A_CTRL_RST), .SKID(0)) u_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_ctrl(a_in_ctrl),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
    .level(a_level)
  );

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST(B_CTRL_RST), .SKID(1)) u_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ctrl(b_in_ctrl),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
    .level(b_level)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare both DUTs' output side against the queue models
  task automatic check_outputs();
    chk("a_out_valid", a_out_valid, qa.size() > 0);
    chk("a_level", a_level, qa.size());
    chk("a_out_ctrl", a_out_ctrl, (qa.size() > 0) ? qa[0].c : A_CTRL_RST);
    if (qa.size() > 0) chk("a_out_data", a_out_data, qa[0].d);
    chk("b_out_valid", b_out_valid, qb.size() > 0);
    chk("b_level", b_level, qb.size());
    chk("b_out_ctrl", b_out_ctrl, (qb.size() > 0) ? qb[0].c : B_CTRL_RST);
    if (qb.size() > 0) chk("b_out_data", b_out_data, qb[0].d);
  endtask

  // One clock: check readiness mid-cycle, advance models at the edge, check outputs after it
  task automatic step();
    @(negedge clk);
    chk("a_in_ready", a_in_ready, (qa.size() == 0) || a_out_ready);
    chk("b_in_ready", b_in_ready, qb.size() < 2);
    a_acc = a_in_valid && ((qa.size() == 0) || a_out_ready);
    b_acc = b_in_valid && (qb.size() < 2);
    @(posedge clk);
    if (flush) begin
      qa.delete();
      qb.delete();
    end else begin
      if (qa.size() > 0 && a_out_ready) void'(qa.pop_front());
      if (a_acc) qa.push_back({a_in_data, a_in_ctrl});
      if (qb.size() > 0 && b_out_ready) void'(qb.pop_front());
      if (b_acc) qb.push_back({b_in_data, b_in_ctrl});
    end
    #1;
    check_outputs();
  endtask

  task automatic drive_rand();
    if (!(a_in_valid && !a_acc)) begin
      a_in_valid = ($urandom_range(0, 3) != 0);
      a_in_data  = {$urandom, $urandom, $urandom};
      a_in_ctrl  = 16'($urandom);
    end
    if (!(b_in_valid && !b_acc)) begin
      b_in_valid = ($urandom_range(0, 3) != 0);
      b_in_data  = {$urandom, $urandom, $urandom};
      b_in_ctrl  = 16'($urandom);
    end
    a_out_ready = ($urandom_range(0, 3) != 0);
    b_out_ready = ($urandom_range(0, 1) != 0);
    flush       = ($urandom_range(0, 19) == 0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_in_ctrl = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_ctrl = '0; b_out_ready = 1'b0;
    a_acc = 1'b0; b_acc = 1'b0;

    @(posedge clk); #1;
    check_outputs();
    chk("a_rst_data", a_out_data, 0);
    chk("b_rst_data", b_out_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();

    // Streaming through the single-register stage
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_ctrl   = 16'h0101;
    for (int k = 1; k <= 4; k++) begin
      a_in_data = DW'(k);
      step();
      chk("stream_data", a_out_data, k);
      chk("stream_valid", a_out_valid, 1);
      chk("stream_ready", a_in_ready, 1);
    end

    // Bubble carries no control
    a_in_valid = 1'b0;
    a_in_ctrl  = 16'hFFFF;
    step();
    chk("bubble_valid", a_out_valid, 0);
    chk("bubble_ctrl", a_out_ctrl, 16'h0000);

    // Replace on simultaneous accept and consume
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 'h70; a_in_ctrl = 16'h0003;
    step();
    a_out_ready = 1'b1; a_in_data = 'h77;
    step();
    chk("replace_data", a_out_data, 'h77);
    chk("replace_level", a_level, 1);
    a_in_valid = 1'b0;
    step();

    // Skid stall and drain in order
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_ctrl = 16'h0042;
    b_in_data = 'hA; step();
    b_in_data = 'hB; step();
    b_in_data = 'hC; step();
    chk("stall_level", b_level, 2);
    chk("stall_in_ready", b_in_ready, 0);
    chk("stall_head", b_out_data, 'hA);
    b_out_ready = 1'b1;
    step();
    chk("drain_b", b_out_data, 'hB);
    step();
    chk("drain_c", b_out_data, 'hC);
    b_in_valid = 1'b0;
    step();
    chk("drain_empty", b_out_valid, 0);

    // Flush collides with an accept
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 'h11;
    step();
    chk("flush_pre_level", b_level, 1);
    flush = 1'b1; b_in_data = 'h55;
    step();
    chk("flush_valid", b_out_valid, 0);
    chk("flush_level", b_level, 0);
    chk("flush_ctrl", b_out_ctrl, B_CTRL_RST);
    flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    step();
    chk("flush_no_55", b_out_valid, 0);

    // Randomised traffic against the models
    for (int i = 0; i < 600; i++) begin
      drive_rand();
      step();
    end
    flush = 1'b0;

    // Asynchronous reset with the skid stage full
    a_in_valid = 1'b0; b_out_ready = 1'b0; b_in_valid = 1'b1;
    qb.delete();
    flush = 1'b1; step(); flush = 1'b0;
    b_in_data = 'h1234; step();
    b_in_data = 'h5678; step();
    chk("pre_rst_level", b_level, 2);
    #1 rst = 1'b1;
    #1;
    qa.delete();
    qb.delete();
    chk("async_rst_valid", b_out_valid, 0);
    chk("async_rst_ctrl", b_out_ctrl, B_CTRL_RST);
    chk("async_rst_level", b_level, 0);
    b_in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", b_in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
